instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_if.sv | 36 +++
 rtl/instr_fetch_branch_lut.sv | 22 ++
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: halt opcode, branch-class
// bit positions and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int INSTR_W = 9;
  localparam int LUT_IDX_W = 5;
  localparam logic [INSTR_W-1:0] kHALT = 9'h07F;
  localparam int BR_NEG_BIT = 8;
  localparam int BR_CLASS_BIT = 6;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    FLUSH,
    DONE
  } state_e;

  // Branch class: top bit clear and class bit set.
  function automatic logic is_branch(input logic [INSTR_W-1:0] ins);
    return !ins[BR_NEG_BIT] && ins[BR_CLASS_BIT];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control inputs, ROM port and decoder-facing outputs.
// Retired_cnt exists only when FETCH_RETIRE_CNT_EN is defined.
interface instr_fetch_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            Stall;
  logic            Branch_req;
  logic [8:0]      Rom_data;
  logic [PC_W-1:0] Rom_addr;
  logic [8:0]      Instruction;
  logic            Instr_valid;
  logic [PC_W-1:0] Pc_out;
  logic            Done;
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0]     Retired_cnt;

  modport master (
    input  Start, Stall, Branch_req, Rom_data,
    output Rom_addr, Instruction, Instr_valid, Pc_out, Done, Retired_cnt
  );
  modport slave (
    output Start, Stall, Branch_req, Rom_data,
    input  Rom_addr, Instruction, Instr_valid, Pc_out, Done, Retired_cnt
  );
`else
  modport master (
    input  Start, Stall, Branch_req, Rom_data,
    output Rom_addr, Instruction, Instr_valid, Pc_out, Done
  );
  modport slave (
    output Start, Stall, Branch_req, Rom_data,
    input  Rom_addr, Instruction, Instr_valid, Pc_out, Done
  );
`endif
endinterface

// File: rtl/instr_fetch_branch_lut.sv
// Constant branch target table, combinational lookup by instruction index.
module branch_lut #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 32
) (
  input  logic [4:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  logic [PC_W-1:0] tgt_tbl [LUT_DEPTH];

  // Entry k targets 16 + 8k (modulo the PC width).
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_ent
    assign tgt_tbl[g] = PC_W'(16 + 8 * g);
  end

  always_comb begin
    target_o = '0;
    if (int'(idx_i) < LUT_DEPTH) target_o = tgt_tbl[idx_i];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC sequencing, stall hold, one-bubble branch redirect, halt.
// Optional FETCH_RETIRE_CNT_EN adds a saturating retired-instruction counter.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  instr_fetch_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pcout_q, pcout_d;
  logic [PC_W-1:0] rom_addr;
  logic [PC_W-1:0] br_target;
  logic            instr_valid;
  logic            done;

  branch_lut #(
    .PC_W     (PC_W),
    .LUT_DEPTH(LUT_DEPTH)
  ) u_lut (
    .idx_i   (bus.Rom_data[LUT_IDX_W-1:0]),
    .target_o(br_target)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pcout_d     = pcout_q;
    rom_addr    = pc_q;
    instr_valid = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        rom_addr = '0;
        if (bus.Start) begin
          state_d = PRIME;
          pc_d    = PC_W'(1);
          pcout_d = '0;
        end
      end
      // Re-read address 0 so the first valid Instruction lines up with Pc_out=0.
      PRIME: begin
        rom_addr = pcout_q;
        state_d  = RUN;
      end
      RUN: begin
        instr_valid = 1'b1;
        if (bus.Stall) begin
          rom_addr = pcout_q;
        end else if (bus.Rom_data == kHALT) begin
          state_d = DONE;
        end else if (is_branch(bus.Rom_data) && bus.Branch_req) begin
          pc_d    = br_target;
          pcout_d = pc_q;
          state_d = FLUSH;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          pcout_d = pc_q;
        end
      end
      FLUSH: begin
        pc_d    = pc_q + PC_W'(1);
        pcout_d = pc_q;
        state_d = RUN;
      end
      DONE: begin
        done = 1'b1;
        if (bus.Start) begin
          state_d = PRIME;
          pc_d    = PC_W'(1);
          pcout_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      pcout_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcout_q <= pcout_d;
    end
  end

  assign bus.Rom_addr    = rom_addr;
  assign bus.Instruction = bus.Rom_data;
  assign bus.Instr_valid = instr_valid;
  assign bus.Pc_out      = pcout_q;
  assign bus.Done        = done;

`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] ret_q, ret_d;
  logic        start_acc;
  logic        retire;

  // The halt instruction itself is never counted as retired.
  assign start_acc = bus.Start && (state_q == IDLE || state_q == DONE);
  assign retire    = instr_valid && !bus.Stall && (bus.Rom_data != kHALT);

  always_comb begin
    ret_d = ret_q;
    if (start_acc)                  ret_d = '0;
    else if (retire && ret_q != '1) ret_d = ret_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) ret_q <= '0;
    else       ret_q <= ret_d;
  end

  assign bus.Retired_cnt = ret_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous ROM model and a PC scoreboard.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int PC_W  = 10;
  localparam int DEPTH = 1 << PC_W;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch #(
    .PC_W     (PC_W),
    .LUT_DEPTH(32)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [8:0] rom [DEPTH];
  int n_chk  = 0;
  int n_fail = 0;
  int exp_q [$];

  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.Rom_data <= rom[bus.Rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back((first + i) % DEPTH);
  endtask

  // One unstalled valid cycle: Pc_out/Instruction must match the next scoreboard entry.
  task automatic check_slot();
    int pc;
    chk("valid", bus.Instr_valid, 1);
    chk("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      pc = exp_q.pop_front();
      chk("pc_out", bus.Pc_out, pc);
      chk("instr", bus.Instruction, rom[pc]);
      chk("rom_addr_run", bus.Rom_addr, (pc + 1) % DEPTH);
    end
  endtask

  task automatic run_valid(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.Stall = 1'b0;
      #1;
      check_slot();
    end
  endtask

  task automatic start_pulse();
    step(); bus.Start = 1'b1; #1;
    chk("start_rom_addr", bus.Rom_addr, 0);
    chk("start_valid", bus.Instr_valid, 0);
    step(); bus.Start = 1'b0; #1;
    chk("prime_valid", bus.Instr_valid, 0);
    chk("prime_rom_addr", bus.Rom_addr, 0);
    chk("prime_done", bus.Done, 0);
    chk("prime_pc_out", bus.Pc_out, 0);
  endtask

  initial begin
    bus.Start      = 1'b0;
    bus.Stall      = 1'b0;
    bus.Branch_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 9'h100 | 9'(i & 255);
    rom[5]  = 9'h043;
    rom[9]  = 9'h043;
    rom[12] = kHALT;

    // Reset state
    step(); #1;
    chk("rst_rom_addr", bus.Rom_addr, 0);
    chk("rst_valid", bus.Instr_valid, 0);
    chk("rst_pc_out", bus.Pc_out, 0);
    chk("rst_done", bus.Done, 0);
    step(); Reset = 1'b0; #1;
    chk("idle_valid", bus.Instr_valid, 0);
    chk("idle_rom_addr", bus.Rom_addr, 0);

    // Start, sequential fetch; branch-class at 5 with Branch_req low falls through
    start_pulse();
    push_range(0, 7);
    run_valid(7);

    // Stall three cycles at 7
    for (int i = 0; i < 3; i++) begin
      step(); bus.Stall = 1'b1; #1;
      chk("stall_valid", bus.Instr_valid, 1);
      chk("stall_pc_out", bus.Pc_out, 7);
      chk("stall_instr", bus.Instruction, rom[7]);
      chk("stall_rom_addr", bus.Rom_addr, 7);
    end
    push_range(7, 2);
    run_valid(2);

    // Stall and Branch_req together at 9: no redirect until Stall drops
    bus.Branch_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); bus.Stall = 1'b1; #1;
      chk("stbr_valid", bus.Instr_valid, 1);
      chk("stbr_pc_out", bus.Pc_out, 9);
      chk("stbr_rom_addr", bus.Rom_addr, 9);
    end
    push_range(9, 1);
    run_valid(1);
    step(); #1;
    chk("flush_valid", bus.Instr_valid, 0);
    chk("flush_rom_addr", bus.Rom_addr, 40);
    push_range(40, 2);
    run_valid(2);
    bus.Branch_req = 1'b0;

    // Mid-run reset, then run to halt at 12
    step(); Reset = 1'b1; #1;
    chk("midrst_valid", bus.Instr_valid, 0);
    chk("midrst_pc_out", bus.Pc_out, 0);
    step(); Reset = 1'b0;
    start_pulse();
    push_range(0, 13);
    run_valid(10);
    step(); #1;
`ifdef FETCH_RETIRE_CNT_EN
    chk("retired_10", bus.Retired_cnt, 10);
`endif
    check_slot();
    run_valid(2);
    step(); #1;
    chk("halt_done", bus.Done, 1);
    chk("halt_valid", bus.Instr_valid, 0);
`ifdef FETCH_RETIRE_CNT_EN
    chk("retired_halt", bus.Retired_cnt, 12);
`endif
    step(); #1;
    chk("done_hold", bus.Done, 1);
    chk("done_pc_out", bus.Pc_out, 12);
    step(); bus.Start = 1'b1; #1;
    chk("done_start_done", bus.Done, 1);
    step(); bus.Start = 1'b0; #1;
    chk("restart_done", bus.Done, 0);
    chk("restart_valid", bus.Instr_valid, 0);
    chk("restart_rom_addr", bus.Rom_addr, 0);
`ifdef FETCH_RETIRE_CNT_EN
    chk("retired_clr", bus.Retired_cnt, 0);
`endif
    push_range(0, 5);
    run_valid(5);

    // Branch at 5 to LUT[3]=40, reset during the FLUSH bubble
    bus.Branch_req = 1'b1;
    push_range(5, 1);
    run_valid(1);
    step(); #1;
    chk("flush2_valid", bus.Instr_valid, 0);
    chk("flush2_rom_addr", bus.Rom_addr, 40);
    #2 Reset = 1'b1;
    #1;
    chk("flrst_rom_addr", bus.Rom_addr, 0);
    chk("flrst_valid", bus.Instr_valid, 0);
    chk("flrst_pc_out", bus.Pc_out, 0);
    chk("flrst_done", bus.Done, 0);
    step(); Reset = 1'b0; bus.Branch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("post_rst_valid", bus.Instr_valid, 0);
      chk("post_rst_rom_addr", bus.Rom_addr, 0);
      chk("post_rst_done", bus.Done, 0);
    end
`ifdef FETCH_RETIRE_CNT_EN
    chk("retired_rst", bus.Retired_cnt, 0);
`endif

    // PC wrap from all-ones to zero
    rom[12] = 9'h10C;
    start_pulse();
    push_range(0, DEPTH + 2);
    run_valid(DEPTH + 2);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
